// File: rtl/rs_branch_jump_age.sv
// Branch/jump reservation station: holds dispatched ops, snoops NUM_CDB result buses for
// missing operands and issues the oldest ready entry to the branch unit (valid/ready).
module rs_branch_jump_age #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned NUM_CDB = 3,
    parameter int unsigned TAG_W   = 6,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned INST_W  = 10
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   kill,
    input  logic                                   we,
    input  logic [INST_W+TAG_W+3*DATA_W+2-1:0]     dc2rs,
    output logic                                   is_full,
    output logic [$clog2(DEPTH+1)-1:0]             free_cnt,
    input  logic [NUM_CDB-1:0]                     cdb_valid,
    input  logic [NUM_CDB*(TAG_W+DATA_W)-1:0]      cdb,
    output logic                                   ex_en,
    input  logic                                   ex_ready,
    output logic [INST_W+TAG_W+3*DATA_W-1:0]       rs2exe
);

    localparam int unsigned CDB_W = TAG_W + DATA_W;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Entry storage
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  v1;
    logic [DEPTH-1:0]  v2;
    logic [DATA_W-1:0] opr1     [DEPTH];
    logic [DATA_W-1:0] opr2     [DEPTH];
    logic [DATA_W-1:0] offset_q [DEPTH];
    logic [TAG_W-1:0]  dest_q   [DEPTH];
    logic [INST_W-1:0] inst_q   [DEPTH];
    // older[i][j] set means entry i was dispatched before entry j
    logic [DEPTH-1:0]  older    [DEPTH];
    logic              lock;
    logic [IDX_W-1:0]  lock_idx;

    // Dispatch payload fields
    logic [INST_W-1:0] d_inst;
    logic [TAG_W-1:0]  d_dest;
    logic              d_v1;
    logic [DATA_W-1:0] d_opr1;
    logic              d_v2;
    logic [DATA_W-1:0] d_opr2;
    logic [DATA_W-1:0] d_off;

    assign d_off  = dc2rs[DATA_W-1:0];
    assign d_opr2 = dc2rs[2*DATA_W-1:DATA_W];
    assign d_v2   = dc2rs[2*DATA_W];
    assign d_opr1 = dc2rs[3*DATA_W:2*DATA_W+1];
    assign d_v1   = dc2rs[3*DATA_W+1];
    assign d_dest = dc2rs[3*DATA_W+2 +: TAG_W];
    assign d_inst = dc2rs[3*DATA_W+2+TAG_W +: INST_W];

    // Returns {hit, data}; lowest-numbered matching bus wins
    function automatic logic [DATA_W:0] snoop(input logic [TAG_W-1:0]         tag,
                                              input logic [NUM_CDB-1:0]       vld,
                                              input logic [NUM_CDB*CDB_W-1:0] bus);
        logic [DATA_W:0] r;
        r = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (!r[DATA_W] && vld[k] && (bus[k*CDB_W+DATA_W +: TAG_W] == tag)) begin
                r = {1'b1, bus[k*CDB_W +: DATA_W]};
            end
        end
        return r;
    endfunction

    logic [DATA_W:0] wk1 [DEPTH];
    logic [DATA_W:0] wk2 [DEPTH];
    logic [DATA_W:0] byp1;
    logic [DATA_W:0] byp2;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wk1[i] = snoop(opr1[i][TAG_W-1:0], cdb_valid, cdb);
            wk2[i] = snoop(opr2[i][TAG_W-1:0], cdb_valid, cdb);
        end
        byp1 = snoop(d_opr1[TAG_W-1:0], cdb_valid, cdb);
        byp2 = snoop(d_opr2[TAG_W-1:0], cdb_valid, cdb);
    end

    logic [DEPTH-1:0] ready;
    logic             oldest_vld;
    logic [IDX_W-1:0] oldest_idx;
    logic             blocked;
    logic [IDX_W-1:0] sel_idx;
    logic             fire;

    // Oldest ready entry: no other ready entry is older than it
    always_comb begin
        ready      = busy & v1 & v2;
        oldest_vld = 1'b0;
        oldest_idx = '0;
        blocked    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                blocked = blocked | (ready[j] & older[j][i]);
            end
            if (ready[i] && !blocked) begin
                oldest_vld = 1'b1;
                oldest_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_idx = lock ? lock_idx : oldest_idx;
        ex_en   = lock | oldest_vld;
        fire    = ex_en & ex_ready;
        rs2exe  = '0;
        if (ex_en) begin
            rs2exe = {inst_q[sel_idx], dest_q[sel_idx], opr1[sel_idx], opr2[sel_idx],
                      offset_q[sel_idx]};
        end
    end

    logic [IDX_W-1:0] alloc_idx;
    logic             alloc_found;
    logic             alloc;

    // Lowest free entry, occupancy status from registered busy only
    always_comb begin
        alloc_idx   = '0;
        alloc_found = 1'b0;
        free_cnt    = CNT_W'(DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            if (!busy[i] && !alloc_found) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
            if (busy[i]) begin
                free_cnt = free_cnt - CNT_W'(1);
            end
        end
        is_full = &busy;
        alloc   = we & ~is_full;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= '0;
            v1       <= '0;
            v2       <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                opr1[i]     <= '0;
                opr2[i]     <= '0;
                offset_q[i] <= '0;
                dest_q[i]   <= '0;
                inst_q[i]   <= '0;
                older[i]    <= '0;
            end
        end else if (kill) begin
            busy <= '0;
            lock <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && !v1[i] && wk1[i][DATA_W]) begin
                    v1[i]   <= 1'b1;
                    opr1[i] <= wk1[i][DATA_W-1:0];
                end
                if (busy[i] && !v2[i] && wk2[i][DATA_W]) begin
                    v2[i]   <= 1'b1;
                    opr2[i] <= wk2[i][DATA_W-1:0];
                end
            end
            // A stalled offer is pinned until accepted
            if (fire) begin
                busy[sel_idx] <= 1'b0;
                lock          <= 1'b0;
            end else if (ex_en) begin
                lock     <= 1'b1;
                lock_idx <= sel_idx;
            end
            if (alloc) begin
                busy[alloc_idx]     <= 1'b1;
                inst_q[alloc_idx]   <= d_inst;
                dest_q[alloc_idx]   <= d_dest;
                offset_q[alloc_idx] <= d_off;
                v1[alloc_idx]       <= d_v1 | byp1[DATA_W];
                v2[alloc_idx]       <= d_v2 | byp2[DATA_W];
                opr1[alloc_idx]     <= (!d_v1 && byp1[DATA_W]) ? byp1[DATA_W-1:0] : d_opr1;
                opr2[alloc_idx]     <= (!d_v2 && byp2[DATA_W]) ? byp2[DATA_W-1:0] : d_opr2;
                for (int j = 0; j < DEPTH; j++) begin
                    older[alloc_idx][j] <= 1'b0;
                    if (IDX_W'(j) != alloc_idx) begin
                        older[j][alloc_idx] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_branch_jump_age.sv
// Bench for rs_branch_jump_age: directed scenarios plus random traffic, all checked against
// a sequence-number based model of the station.
module tb_rs_branch_jump_age;

    localparam int DEPTH = 4;
    localparam int NCDB  = 3;
    localparam int TW    = 6;
    localparam int DW    = 32;
    localparam int IW    = 10;
    localparam int IN_W  = IW + TW + 3*DW + 2;
    localparam int OUT_W = IW + TW + 3*DW;
    localparam int CW    = TW + DW;

    logic              clk = 1'b0;
    logic              reset;
    logic              kill;
    logic              we;
    logic [IN_W-1:0]   dc2rs;
    logic              is_full;
    logic [2:0]        free_cnt;
    logic [NCDB-1:0]   cdb_valid;
    logic [NCDB*CW-1:0] cdb;
    logic              ex_en;
    logic              ex_ready;
    logic [OUT_W-1:0]  rs2exe;

    rs_branch_jump_age #(.DEPTH(DEPTH), .NUM_CDB(NCDB), .TAG_W(TW), .DATA_W(DW), .INST_W(IW)) dut (
        .clk(clk), .reset(reset), .kill(kill), .we(we), .dc2rs(dc2rs), .is_full(is_full),
        .free_cnt(free_cnt), .cdb_valid(cdb_valid), .cdb(cdb), .ex_en(ex_en),
        .ex_ready(ex_ready), .rs2exe(rs2exe));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: entries ordered by a global dispatch sequence number
    bit              m_busy [DEPTH];
    bit              m_v1   [DEPTH];
    bit              m_v2   [DEPTH];
    logic [DW-1:0]   m_o1   [DEPTH];
    logic [DW-1:0]   m_o2   [DEPTH];
    logic [DW-1:0]   m_off  [DEPTH];
    logic [TW-1:0]   m_dest [DEPTH];
    logic [IW-1:0]   m_inst [DEPTH];
    int              m_seq  [DEPTH];
    bit              m_lock;
    int              m_lidx;
    int              seq_ctr = 0;

    function automatic void m_reset();
        for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
        m_lock = 1'b0;
    endfunction

    function automatic int m_free();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) n++;
        return n;
    endfunction

    task automatic m_select(output bit en, output int idx);
        en = 1'b0;
        idx = 0;
        if (m_lock) begin
            en = 1'b1;
            idx = m_lidx;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (m_busy[i] && m_v1[i] && m_v2[i] && (!en || m_seq[i] < m_seq[idx])) begin
                    en = 1'b1;
                    idx = i;
                end
        end
    endtask

    function automatic bit snoop(input logic [TW-1:0] t, output logic [DW-1:0] d);
        logic [CW-1:0] bus;
        d = '0;
        for (int k = 0; k < NCDB; k++) begin
            bus = cdb[k*CW +: CW];
            if (cdb_valid[k] && bus[CW-1:DW] == t) begin
                d = bus[DW-1:0];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic check_outputs();
        bit en;
        int idx;
        logic [OUT_W-1:0] exp_out;
        m_select(en, idx);
        exp_out = '0;
        if (en) exp_out = {m_inst[idx], m_dest[idx], m_o1[idx], m_o2[idx], m_off[idx]};
        check("ex_en", ex_en, en);
        check("rs2exe", rs2exe, exp_out);
        check("is_full", is_full, m_free() == 0);
        check("free_cnt", free_cnt, m_free());
    endtask

    task automatic m_step();
        bit en;
        int idx;
        int slot;
        logic [DW-1:0] d;
        if (kill) begin
            m_reset();
            return;
        end
        m_select(en, idx);
        slot = -1;
        for (int i = DEPTH-1; i >= 0; i--) if (!m_busy[i]) slot = i;
        for (int i = 0; i < DEPTH; i++) if (m_busy[i]) begin
            if (!m_v1[i] && snoop(m_o1[i][TW-1:0], d)) begin m_v1[i] = 1'b1; m_o1[i] = d; end
            if (!m_v2[i] && snoop(m_o2[i][TW-1:0], d)) begin m_v2[i] = 1'b1; m_o2[i] = d; end
        end
        if (en && ex_ready) begin
            m_busy[idx] = 1'b0;
            m_lock = 1'b0;
        end else if (en) begin
            m_lock = 1'b1;
            m_lidx = idx;
        end
        if (we && slot >= 0) begin
            m_busy[slot] = 1'b1;
            m_off[slot]  = dc2rs[31:0];
            m_o2[slot]   = dc2rs[63:32];
            m_v2[slot]   = dc2rs[64];
            m_o1[slot]   = dc2rs[96:65];
            m_v1[slot]   = dc2rs[97];
            m_dest[slot] = dc2rs[103:98];
            m_inst[slot] = dc2rs[113:104];
            if (!m_v1[slot] && snoop(m_o1[slot][TW-1:0], d)) begin m_v1[slot] = 1'b1; m_o1[slot] = d; end
            if (!m_v2[slot] && snoop(m_o2[slot][TW-1:0], d)) begin m_v2[slot] = 1'b1; m_o2[slot] = d; end
            m_seq[slot] = seq_ctr++;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_outputs();
        m_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IN_W-1:0] mk_op(input logic [IW-1:0] inst, input logic [TW-1:0] dest,
                                              input logic v1, input logic [DW-1:0] o1,
                                              input logic v2, input logic [DW-1:0] o2,
                                              input logic [DW-1:0] off);
        return {inst, dest, v1, o1, v2, o2, off};
    endfunction

    task automatic idle();
        we = 1'b0; kill = 1'b0; cdb_valid = '0; cdb = '0; ex_ready = 1'b1; dc2rs = '0;
    endtask

    task automatic set_cdb(input int k, input logic [TW-1:0] t, input logic [DW-1:0] d);
        cdb[k*CW +: CW] = {t, d};
        cdb_valid[k] = 1'b1;
    endtask

    task automatic dispatch(input logic [TW-1:0] dest, input logic v1, input logic [DW-1:0] o1);
        we = 1'b1;
        dc2rs = mk_op(IW'(dest) + 10'd100, dest, v1, o1, 1'b1, 32'h20 + 32'(dest), 32'h40 + 32'(dest));
        cyc();
        we = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Async reset with three busy entries and a stalled offer
        ex_ready = 1'b0;
        dispatch(6'd1, 1'b0, 32'd40);
        dispatch(6'd2, 1'b1, 32'h11);
        dispatch(6'd3, 1'b0, 32'd41);
        check("t1_pre_free", free_cnt, 3'd1);
        check("t1_pre_en", ex_en, 1'b1);
        reset = 1'b1;
        #1;
        check("t1_en", ex_en, 1'b0);
        check("t1_free", free_cnt, 3'd4);
        check("t1_full", is_full, 1'b0);
        check("t1_out", rs2exe, '0);
        m_reset();
        @(negedge clk);
        reset = 1'b0;
        idle();
        @(posedge clk);
        #1;

        // Oldest-ready ordering: B, C, then A after wakeup
        dispatch(6'd1, 1'b0, 32'd5);
        check("t2_a_wait", ex_en, 1'b0);
        dispatch(6'd2, 1'b1, 32'h22);
        check("t2_b", rs2exe[3*DW +: TW], 6'd2);
        dispatch(6'd3, 1'b1, 32'h33);
        check("t2_c", rs2exe[3*DW +: TW], 6'd3);
        set_cdb(0, 6'd5, 32'h100);
        cyc();
        idle();
        check("t2_a", rs2exe[3*DW +: TW], 6'd1);
        check("t2_a_opr1", rs2exe[2*DW +: DW], 32'h100);
        cyc();
        check("t2_empty", ex_en, 1'b0);

        // Fill, overflow dispatch dropped, then one accept
        for (int i = 0; i < 4; i++) dispatch(6'(i + 4), 1'b0, 32'd20);
        check("t3_full", is_full, 1'b1);
        check("t3_free0", free_cnt, 3'd0);
        dispatch(6'd9, 1'b1, 32'h99);
        check("t3_drop", free_cnt, 3'd0);
        set_cdb(1, 6'd20, 32'h55);
        cyc();
        idle();
        check("t3_first", rs2exe[3*DW +: TW], 6'd4);
        cyc();
        check("t3_free1", free_cnt, 3'd1);
        kill = 1'b1;
        cyc();
        idle();

        // Stalled offer stays put while an older entry wakes
        ex_ready = 1'b0;
        dispatch(6'd11, 1'b0, 32'd30);
        dispatch(6'd12, 1'b0, 32'd31);
        dispatch(6'd13, 1'b1, 32'h13);
        check("t4_offer", rs2exe[3*DW +: TW], 6'd13);
        cyc();
        set_cdb(0, 6'd30, 32'h77);
        cyc();
        cdb_valid = '0;
        check("t4_hold1", rs2exe[3*DW +: TW], 6'd13);
        cyc();
        check("t4_hold2", rs2exe[3*DW +: TW], 6'd13);
        ex_ready = 1'b1;
        cyc();
        check("t4_older", rs2exe[3*DW +: TW], 6'd11);
        check("t4_opr1", rs2exe[2*DW +: DW], 32'h77);

        // Kill with dispatch and pending handshake
        we = 1'b1;
        kill = 1'b1;
        dc2rs = mk_op(10'd7, 6'd14, 1'b1, 32'h1, 1'b1, 32'h2, 32'h3);
        cyc();
        idle();
        check("t6_en", ex_en, 1'b0);
        check("t6_free", free_cnt, 3'd4);
        check("t6_full", is_full, 1'b0);
        cyc();
        check("t6_en_after", ex_en, 1'b0);

        // Dispatch bypass from bus 2
        we = 1'b1;
        dc2rs = mk_op(10'd9, 6'd21, 1'b0, 32'd9, 1'b1, 32'h3, 32'h4);
        set_cdb(2, 6'd9, 32'hDEAD);
        cyc();
        idle();
        check("t5_en", ex_en, 1'b1);
        check("t5_opr1", rs2exe[2*DW +: DW], 32'hDEAD);
        cyc();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic v1r;
            logic v2r;
            v1r = ($urandom_range(0, 2) != 0);
            v2r = ($urandom_range(0, 2) != 0);
            we = ($urandom_range(0, 9) < 6);
            dc2rs = mk_op(IW'($urandom), TW'($urandom), v1r,
                          v1r ? 32'($urandom) : 32'($urandom_range(0, 7)), v2r,
                          v2r ? 32'($urandom) : 32'($urandom_range(0, 7)), 32'($urandom));
            cdb = '0;
            cdb_valid = '0;
            for (int k = 0; k < NCDB; k++)
                if ($urandom_range(0, 9) < 4) set_cdb(k, TW'($urandom_range(0, 7)), 32'($urandom));
            ex_ready = ($urandom_range(0, 9) < 7);
            kill = ($urandom_range(0, 49) == 0);
            cyc();
        end
        idle();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
